control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
Pipelined successor to the combinational ID-stage control decoder. It decodes op_code into EX/M/WB control fields and registers them as the ID/EX control pipeline stage. It adds load-use hazard detection with a parametrised bubble count, branch flush, and illegal-opcode flagging and counting. It sits between the IF/ID register and the EX stage, and drives the PC and IF/ID write enables.

Parameters:
REG_ADDR_W, 5, register-specifier width for rs/rt.
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..3; use 2 for a pipeline without forwarding.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
op_code  input  6  opcode of the instruction in IF/ID
id_valid  input  1  IF/ID holds a real instruction
id_rs  input  REG_ADDR_W  rs of the ID instruction
id_rt  input  REG_ADDR_W  rt of the ID instruction
flush  input  1  branch taken in MEM; squash the ID instruction
EX  output  4  registered {RegDst, ALUOp[1:0], ALUSrc}
M  output  3  registered {Branch, MemRead, MemWrite}
WB  output  2  registered {RegWrite, MemToReg}
ex_rt  output  REG_ADDR_W  registered rt accompanying the ID/EX control
pc_write  output  1  combinational; 0 while stalling
ifid_write  output  1  combinational; equals pc_write
illegal  output  1  registered one-cycle pulse for an unrecognised opcode that advanced
illegal_cnt  output  CNT_W  saturating count of illegal opcodes
jump  output  1  registered; only used with the optional feature

Behaviour:
- Reset (async, rst_n=0): EX, M, WB, ex_rt, illegal, jump, illegal_cnt all 0. Stall counter 0; state RUN. pc_write=ifid_write=1 while in reset.
- Decode table (EX/M/WB):
  - RTYPE 000000: 1100/000/10
  - LW 100011: 0001/010/11
  - SW 101011: 0001/001/00
  - BEQ 000100: 0010/100/00
  - NOP 100000: all 0
  - Any other opcode: all 0, classed illegal.
  - id_valid=0 decodes as a bubble (all 0).
- Latency: 1 cycle from op_code/id_rs/id_rt to EX/M/WB/ex_rt.
- Hazard condition (combinational):
  - M[1]=1 (LW in ID/EX), id_valid=1, ex_rt!=0, and
  - ex_rt==id_rs, or ex_rt==id_rt with op_code in {RTYPE, SW, BEQ}.
- State machine RUN/STALL with stall counter scnt of width 2:
  - RUN, hazard=1: pc_write=ifid_write=0. ID/EX loads a bubble (EX/M/WB=0, ex_rt=0). If LOAD_USE_STALLS>1, go to STALL with scnt=LOAD_USE_STALLS-1; otherwise stay in RUN.
  - RUN, no hazard: ID/EX loads the decoded instruction; pc_write=1.
  - STALL: pc_write=ifid_write=0; ID/EX loads a bubble; scnt decrements. When scnt==1 the next state is RUN. The hazard check is ignored in STALL because ex_rt is 0.
- flush=1 has highest priority in any state:
  - ID/EX loads a bubble; state goes to RUN; scnt goes to 0.
  - pc_write=ifid_write=1 in that cycle; no illegal pulse or count.
- Illegal handling:
  - illegal pulses and illegal_cnt increments only when an unrecognised opcode with id_valid=1 advances into ID/EX (not stalled, not flushed).
  - A held instruction is counted once.
  - illegal_cnt saturates at 2^CNT_W-1.
- Reset asserted mid-stall aborts the stall immediately; the first cycle after release is in RUN.
- No $display or simulation-only side effects in synthesised logic.

Optional Feature:
CTRL_EXT_OPS_EN:
- Defined: ADDI 001000 decodes to 0001/000/10. J 000010 decodes to 0/0/0 and sets jump=1 for the cycle it sits in ID/EX. Neither opcode is illegal. ADDI participates in the hazard check via rs only.
- Undefined: both opcodes are illegal and jump is tied to 0.

Test Plan:
- Reset: rst_n=0 mid-run with LW in ID/EX -> EX/M/WB=0, illegal_cnt=0, pc_write=1 asynchronously; after release, RTYPE -> EX=1100, WB=10 one cycle later.
- Decode sweep: RTYPE, LW, SW, BEQ, NOP on consecutive cycles -> outputs match the table with 1-cycle latency; illegal stays 0.
- Load-use, default: LW rt=5, then RTYPE rs=5 -> pc_write=0 for exactly 1 cycle, one bubble, then RTYPE decoded (EX=1100); with rt=0 -> no stall.
- LOAD_USE_STALLS=2: LW rt=3, then SW rt=3 -> 2 stall cycles, 2 bubbles, then SW 0001/001/00.
- Flush during stall: LOAD_USE_STALLS=3, flush=1 in the second stall cycle -> bubble loaded, pc_write=1 that cycle, state RUN.
- Illegal: opcode 111111 held through a 1-cycle stall, then advanced -> one illegal pulse, illegal_cnt=1; with CNT_W=2, feed 5 illegal opcodes -> illegal_cnt=3 (saturated).

Source files
------------

// File: rtl/control_pipe.sv
// control_pipe: ID-stage control decode registered into ID/EX, with load-use stall, flush and illegal-opcode tracking.
// Define CTRL_EXT_OPS_EN to decode ADDI and J (J raises jump while it sits in ID/EX).
module control_pipe #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            op_code,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    output logic [3:0]            EX,
    output logic [2:0]            M,
    output logic [1:0]            WB,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  illegal,
    output logic [CNT_W-1:0]      illegal_cnt,
    output logic                  jump
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_NOP   = 6'b100000;
`ifdef CTRL_EXT_OPS_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    logic dec_j;
`endif

    typedef enum logic {RUN, STALL} state_t;

    state_t     state;
    logic [1:0] scnt;
    logic [8:0] dec;
    logic       dec_ill;
    logic       uses_rt;
    logic       hazard;
    logic       stall;
    logic       adv;

    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
`ifdef CTRL_EXT_OPS_EN
        dec_j   = 1'b0;
`endif
        case (op_code)
            OP_RTYPE: dec = 9'b1100_000_10;
            OP_LW:    dec = 9'b0001_010_11;
            OP_SW:    dec = 9'b0001_001_00;
            OP_BEQ:   dec = 9'b0010_100_00;
            OP_NOP:   dec = '0;
`ifdef CTRL_EXT_OPS_EN
            OP_ADDI:  dec = 9'b0001_000_10;
            OP_J:     dec_j = 1'b1;
`endif
            default:  dec_ill = 1'b1;
        endcase
    end

    // ex_rt is cleared on every bubble, so the check is inert while stalling
    assign uses_rt    = op_code inside {OP_RTYPE, OP_SW, OP_BEQ};
    assign hazard     = M[1] && id_valid && (|ex_rt) && (ex_rt == id_rs || (ex_rt == id_rt && uses_rt));
    assign stall      = !flush && (state == STALL || hazard);
    assign adv        = !stall && !flush && id_valid;
    assign pc_write   = !stall;
    assign ifid_write = pc_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {EX, M, WB} <= '0;
            ex_rt       <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
            state       <= RUN;
            scnt        <= '0;
        end else begin
            {EX, M, WB} <= adv ? dec : '0;
            ex_rt       <= adv ? id_rt : '0;
            illegal     <= adv && dec_ill;
            illegal_cnt <= illegal_cnt + CNT_W'(adv && dec_ill && !(&illegal_cnt));
            if (flush) begin
                state <= RUN;
                scnt  <= '0;
            end else if (state == STALL) begin
                scnt <= scnt - 2'd1;
                if (scnt == 2'd1)
                    state <= RUN;
            end else if (hazard && LOAD_USE_STALLS > 1) begin
                state <= STALL;
                scnt  <= 2'(LOAD_USE_STALLS - 1);
            end
        end
    end

`ifdef CTRL_EXT_OPS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            jump <= 1'b0;
        else
            jump <= adv && dec_j;
    end
`else
    assign jump = 1'b0;
`endif
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: scoreboard bench; a remaining-bubble model predicts ID/EX contents and pc_write.
module tb_control_pipe;
    localparam int AW = 5;
    localparam int ST = 3;
    localparam int CW = 3;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [5:0]    op_code = 0;
    logic          id_valid = 0;
    logic [AW-1:0] id_rs = 0;
    logic [AW-1:0] id_rt = 0;
    logic          flush = 0;
    logic [3:0]    EX;
    logic [2:0]    M;
    logic [1:0]    WB;
    logic [AW-1:0] ex_rt;
    logic          pc_write;
    logic          ifid_write;
    logic          illegal;
    logic [CW-1:0] illegal_cnt;
    logic          jump;

    control_pipe #(.REG_ADDR_W(AW), .LOAD_USE_STALLS(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .EX(EX), .M(M), .WB(WB),
        .ex_rt(ex_rt), .pc_write(pc_write), .ifid_write(ifid_write),
        .illegal(illegal), .illegal_cnt(illegal_cnt), .jump(jump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]    ctl;
        logic [AW-1:0] rt;
        logic          ill;
        logic [CW-1:0] cnt;
        logic          j;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    bit            m_ld;
    logic [AW-1:0] m_rt;
    int            rem;
    int            cnt;
    bit            mpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] dec(input logic [5:0] op);
        case (op)
            6'd0:  return 9'b1100_000_10;
            6'd35: return 9'b0001_010_11;
            6'd43: return 9'b0001_001_00;
            6'd4:  return 9'b0010_100_00;
`ifdef CTRL_EXT_OPS_EN
            6'd8:  return 9'b0001_000_10;
`endif
            default: return 9'b0;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
`ifdef CTRL_EXT_OPS_EN
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd32, 6'd8, 6'd2};
`else
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd32};
`endif
    endfunction

    task automatic step(input logic [5:0] op, input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic fl);
        exp_t e;
        bit   haz;
        op_code = op; id_valid = v; id_rs = rs; id_rt = rt; flush = fl;
        haz = m_ld && v && m_rt != 0 && (m_rt == rs || (m_rt == rt && op inside {6'd0, 6'd43, 6'd4}));
        e.ctl = 0; e.rt = 0; e.ill = 0; e.j = 0;
        if (fl) begin
            mpc = 1; rem = 0;
        end else if (rem > 0) begin
            mpc = 0; rem--;
        end else if (haz) begin
            mpc = 0; rem = ST - 1;
        end else begin
            mpc = 1;
            if (v) begin
                e.ctl = dec(op);
                e.rt  = rt;
                e.ill = !legal(op);
`ifdef CTRL_EXT_OPS_EN
                e.j   = (op == 6'd2);
`endif
                if (e.ill && cnt < 2**CW - 1) cnt++;
            end
        end
        e.cnt = cnt[CW-1:0];
        #1;
        chk("pc_write", pc_write, mpc);
        chk("ifid_write", ifid_write, mpc);
        @(posedge clk);
        q.push_back(e);
        m_ld = e.ctl[3];
        m_rt = e.rt;
        @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt, input int fl_at);
        int n = 0;
        do begin
            n++;
            step(op, 1'b1, rs, rt, n == fl_at);
        end while (!mpc && n < 12);
        if (!mpc) begin
            total++; bad++;
            $display("FAIL issue_timeout op=%0h cycles=%0d", op, n);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_ctl", {EX, M, WB}, 0);
        chk("rst_ex_rt", ex_rt, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_pc_write", pc_write, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        m_ld = 0; m_rt = 0; rem = 0; cnt = 0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("EX", EX, e.ctl[8:5]);
                chk("M", M, e.ctl[4:2]);
                chk("WB", WB, e.ctl[1:0]);
                chk("ex_rt", ex_rt, e.rt);
                chk("illegal", illegal, e.ill);
                chk("illegal_cnt", illegal_cnt, e.cnt);
                chk("jump", jump, e.j);
            end
        end
    end

    initial begin
        logic [5:0] ops[8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd32, 6'd8, 6'd2, 6'd63};
        logic [5:0] op;
        logic [AW-1:0] rs, rt;
        logic v;
        @(negedge clk);
        do_reset();
        issue(6'd0, 1, 2, 0);
        issue(6'd35, 0, 6, 0);
        issue(6'd43, 7, 8, 0);
        issue(6'd4, 1, 2, 0);
        issue(6'd32, 0, 0, 0);
        issue(6'd35, 0, 5, 0);
        issue(6'd0, 5, 1, 0);
        issue(6'd35, 1, 0, 0);
        issue(6'd0, 0, 0, 0);
        issue(6'd35, 0, 3, 0);
        issue(6'd43, 1, 3, 0);
        issue(6'd35, 0, 3, 0);
        issue(6'd0, 3, 2, 2);
        issue(6'd35, 0, 4, 0);
        issue(6'd63, 4, 0, 0);
        issue(6'd35, 0, 9, 0);
        do_reset();
        issue(6'd0, 1, 2, 0);
        repeat (9) issue(6'd63, 0, 0, 0);
        op = 0; rs = 0; rt = 0; v = 1;
        for (int i = 0; i < 400; i++) begin
            if (i == 0 || mpc) begin
                op = ops[$urandom_range(0, 7)];
                if ($urandom_range(0, 7) == 0) op = 6'($urandom);
                rs = AW'($urandom_range(0, 3));
                rt = AW'($urandom_range(0, 3));
                v  = $urandom_range(0, 9) != 0;
            end
            step(op, v, rs, rt, $urandom_range(0, 19) == 0);
        end
        repeat (2) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
